// File: rtl/mc_pkg.sv
// Shared types and width helper for the Monte Carlo sample controller.
package mc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } mc_state_e;

    // Width of rnd_z and of f = A*x + B*y. It is generous enough that f cannot overflow.
    function automatic int unsigned fw(input int unsigned width, input int unsigned a,
                                       input int unsigned b);
        return width + a + b;
    endfunction

endpackage

// File: rtl/mc_eval_stage.sv
// Two-stage evaluator: stage 1 captures (x, y, z); stage 2 registers hit = (z < A*x + B*y).
module mc_eval_stage
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned A     = 2,
    parameter int unsigned B     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        valid,
    input  logic [WIDTH-1:0]            x,
    input  logic [WIDTH-1:0]            y,
    input  logic [fw(WIDTH, A, B)-1:0]  z,
    output logic                        hit_valid,
    output logic                        hit
);

    localparam int unsigned FW = fw(WIDTH, A, B);
    localparam logic [FW-1:0] ACoef = FW'(A);
    localparam logic [FW-1:0] BCoef = FW'(B);

    logic             s1_valid_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [FW-1:0]    z_q;
    logic [FW-1:0]    f;
    logic             hit_valid_q;
    logic             hit_q;

    always_comb begin
        f = ACoef * FW'(x_q) + BCoef * FW'(y_q);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid_q  <= 1'b0;
            hit_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= valid;
            hit_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            hit_q <= 1'b0;
        end else begin
            if (valid) begin
                x_q <= x;
                y_q <= y;
                z_q <= z;
            end
            hit_q <= (z_q < f);
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit       = hit_q;

endmodule

// File: rtl/mc_sample_ctrl.sv
// Monte Carlo run controller: start/busy/done FSM, RNG handshake and hit counting.
// Optional MC_ABORT_EN adds an abort input that ends a run early without a done pulse.
module mc_sample_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned A     = 2,
    parameter int unsigned B     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef MC_ABORT_EN
    input  logic                        abort,
`endif
    input  logic                        start,
    input  logic [CNT_W-1:0]            n_samples,
    input  logic [WIDTH-1:0]            rnd_x,
    input  logic [WIDTH-1:0]            rnd_y,
    input  logic [fw(WIDTH, A, B)-1:0]  rnd_z,
    input  logic                        rnd_valid,
    output logic                        rnd_ready,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            hits
);

    localparam logic [CNT_W-1:0] HitsMax = '1;

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic             s1_pend_q;
    logic             handshake;
    logic             kill;
    logic             hit_valid;
    logic             hit;

`ifdef MC_ABORT_EN
    assign kill = abort && (state_q == StRun || state_q == StDrain);
`else
    assign kill = 1'b0;
`endif

    assign rnd_ready = (state_q == StRun) && !kill;
    assign handshake = rnd_valid && rnd_ready;

    mc_eval_stage #(
        .WIDTH (WIDTH),
        .A     (A),
        .B     (B)
    ) u_eval (
        .clk       (clk),
        .rst       (rst),
        .flush     (kill),
        .valid     (handshake),
        .x         (rnd_x),
        .y         (rnd_y),
        .z         (rnd_z),
        .hit_valid (hit_valid),
        .hit       (hit)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        issued_d = issued_q;
        hits_d   = hits_q;

        // A stage-2 hit still lands on the abort edge; only stage 1 is dropped.
        if (hit_valid && hit && hits_q != HitsMax) begin
            hits_d = hits_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d      = n_samples;
                    issued_d = '0;
                    hits_d   = '0;
                    state_d  = (n_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (handshake) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_d == n_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!s1_pend_q && !hit_valid) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (kill) begin
            state_d = StIdle;
        end
    end

    // s1_pend_q mirrors the stage-1 valid so the drain check sees the whole pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= '0;
            issued_q  <= '0;
            hits_q    <= '0;
            s1_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            issued_q  <= issued_d;
            hits_q    <= hits_d;
            s1_pend_q <= handshake;
        end
    end

    assign busy = (state_q == StRun) || (state_q == StDrain);
    assign done = (state_q == StDone);
    assign hits = hits_q;

endmodule

// File: tb/tb_mc_sample_ctrl.sv
// Self-checking bench for mc_sample_ctrl against a counting model of the hit rule.
module tb_mc_sample_ctrl;

    localparam int WIDTH = 10;
    localparam int A     = 2;
    localparam int B     = 3;
    localparam int CNT_W = 16;
    localparam int FW    = WIDTH + A + B;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic [WIDTH-1:0] rnd_x;
    logic [WIDTH-1:0] rnd_y;
    logic [FW-1:0]    rnd_z;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;
`ifdef MC_ABORT_EN
    logic             abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int qx[$];
    int qy[$];
    int qz[$];

    mc_sample_ctrl #(
        .WIDTH (WIDTH),
        .A     (A),
        .B     (B),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MC_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .n_samples (n_samples),
        .rnd_x     (rnd_x),
        .rnd_y     (rnd_y),
        .rnd_z     (rnd_z),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy),
        .done      (done),
        .hits      (hits)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A sample scores when its threshold lies strictly below A*x + B*y.
    function automatic bit ref_hit(input int x, input int y, input int z);
        return z < (A * x + B * y);
    endfunction

    function automatic void push_triple(input int x, input int y, input int z);
        qx.push_back(x);
        qy.push_back(y);
        qz.push_back(z);
    endfunction

    // mode 0: valid every cycle, 1: every other cycle, 2: random gaps.
    task automatic do_run(input int n, input int mode, input bit poke_start);
        int hs;
        int cyc;
        int exp_hits;
        int vx;
        int vy;
        int vz;
        bit v;
        hs       = 0;
        cyc      = 0;
        exp_hits = 0;
        n_samples = CNT_W'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        n_samples = CNT_W'($urandom);
        if (n == 0) begin
            check("zero_done", 32'(done), 1);
            check("zero_hits", 32'(hits), 0);
            check("zero_ready", 32'(rnd_ready), 0);
            check("zero_busy", 32'(busy), 0);
            tick();
            check("zero_done_pulse", 32'(done), 0);
            check("zero_ready_after", 32'(rnd_ready), 0);
            return;
        end
        while (hs < n && cyc < 200) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            if (v && qx.size() > 0) begin
                vx = qx.pop_front();
                vy = qy.pop_front();
                vz = qz.pop_front();
            end else begin
                vx = $urandom_range(0, 1023);
                vy = $urandom_range(0, 1023);
                vz = $urandom_range(0, 6000);
            end
            rnd_valid = v;
            rnd_x     = WIDTH'(vx);
            rnd_y     = WIDTH'(vy);
            rnd_z     = FW'(vz);
            start     = poke_start && (cyc == 3);
            if (poke_start && cyc == 3) n_samples = CNT_W'(7);
            check("ready_in_run", 32'(rnd_ready), 1);
            check("busy_in_run", 32'(busy), 1);
            if (v && rnd_ready) begin
                hs++;
                if (ref_hit(vx, vy, vz)) exp_hits++;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        rnd_valid = 1'b0;
        check("handshakes", 32'(hs), 32'(n));
        check("ready_after_last", 32'(rnd_ready), 0);
        check("busy_drain", 32'(busy), 1);
        tick();
        check("done_early1", 32'(done), 0);
        check("ready_drain", 32'(rnd_ready), 0);
        tick();
        check("done_early2", 32'(done), 0);
        tick();
        check("done_latency", 32'(done), 1);
        check("busy_at_done", 32'(busy), 0);
        check("hits", 32'(hits), 32'(exp_hits));
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("hits_hold", 32'(hits), 32'(exp_hits));
        for (int i = 0; i < 3; i++) begin
            check("idle_after_run", 32'(busy), 0);
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        n_samples = '0;
        rnd_x     = '0;
        rnd_y     = '0;
        rnd_z     = '0;
        rnd_valid = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(rnd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_hits", 32'(hits), 0);
        rst = 1'b0;
        tick();

        // Triples offered while idle are never accepted.
        rnd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("idle_ready", 32'(rnd_ready), 0);
            tick();
        end
        rnd_valid = 1'b0;

        push_triple(10, 20, 79);
        do_run(1, 0, 1'b0);
        push_triple(10, 20, 80);
        do_run(1, 0, 1'b0);
        do_run(0, 0, 1'b0);

        push_triple(10, 20, 79);
        push_triple(10, 20, 80);
        push_triple(1, 1, 0);
        push_triple(100, 100, 499);
        do_run(4, 1, 1'b1);

        do_run(8, 0, 1'b0);
        do_run($urandom_range(5, 20), 2, 1'b0);
        do_run($urandom_range(5, 20), 2, 1'b0);

        // Reset in the middle of a run.
        n_samples = CNT_W'(10);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        rnd_valid = 1'b1;
        rnd_x     = WIDTH'(1);
        rnd_y     = WIDTH'(1);
        rnd_z     = '0;
        tick();
        tick();
        rnd_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_hits", 32'(hits), 0);
        check("mid_rst_ready", 32'(rnd_ready), 0);
        check("mid_rst_done", 32'(done), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_done", 32'(done), 0);
        end

`ifdef MC_ABORT_EN
        n_samples = CNT_W'(10);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        rnd_valid = 1'b1;
        rnd_x     = WIDTH'(1);
        rnd_y     = WIDTH'(1);
        rnd_z     = '0;
        tick();
        tick();
        rnd_valid = 1'b0;
        tick();
        tick();
        check("abort_pre_hits", 32'(hits), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_hits", 32'(hits), 2);
        check("abort_ready", 32'(rnd_ready), 0);
        check("abort_done", 32'(done), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_done", 32'(done), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
